// File: rtl/sram_arbiter_2p_if.sv
// Port A/B request buses plus the SRAM pin-side signals of the two-port SRAM arbiter.
// slave = arbiter side, master = requesters / pad ring side.
interface sram_arbiter_2p_if #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 8
);
    logic              req_a;
    logic              we_a;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] wdata_a;
    logic [DATA_W-1:0] rdata_a;
    logic              ack_a;

    logic              req_b;
    logic              we_b;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wdata_b;
    logic [DATA_W-1:0] rdata_b;
    logic              ack_b;

    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_data_o;
    logic              sram_data_oe;
    logic [DATA_W-1:0] sram_data_i;
    logic              sram_we_n;
    logic              busy;

    modport slave (
        input  req_a, we_a, addr_a, wdata_a,
        input  req_b, we_b, addr_b, wdata_b,
        input  sram_data_i,
        output rdata_a, ack_a, rdata_b, ack_b,
        output sram_addr, sram_data_o, sram_data_oe, sram_we_n, busy
    );

    modport master (
        output req_a, we_a, addr_a, wdata_a,
        output req_b, we_b, addr_b, wdata_b,
        output sram_data_i,
        input  rdata_a, ack_a, rdata_b, ack_b,
        input  sram_addr, sram_data_o, sram_data_oe, sram_we_n, busy
    );
endinterface

// File: rtl/sram_arbiter_2p.sv
// Round-robin two-port arbiter/sequencer for one async SRAM: IDLE->SETUP->ACCESS(xWAIT_CYCLES)->RECOVER.
// Ack in cycle WAIT_CYCLES+2 after the request is sampled; requesters hold req until ack, all outputs registered.
module sram_arbiter_2p #(
    parameter int ADDR_W      = 21,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 3
) (
    input  logic                 clk_chipset,
    input  logic                 reset,
    sram_arbiter_2p_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RECOVER} state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              port_q, port_d;        // 0 = A, 1 = B
    logic              last_b_q, last_b_d;    // last served port was B
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0] sram_data_o_q, sram_data_o_d;
    logic              sram_data_oe_q, sram_data_oe_d;
    logic              sram_we_n_q, sram_we_n_d;
    logic              ack_a_q, ack_a_d;
    logic              ack_b_q, ack_b_d;
    logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
    logic [DATA_W-1:0] rdata_b_q, rdata_b_d;
    logic              busy_q, busy_d;
    logic              grant_vld;
    logic              grant_b;

    // Tie goes to the port that was not served last.
    assign grant_vld = bus.req_a || bus.req_b;
    assign grant_b   = bus.req_b && (!bus.req_a || !last_b_q);

    always_ff @(posedge clk_chipset) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            we_q           <= 1'b0;
            port_q         <= 1'b0;
            last_b_q       <= 1'b1;
            sram_addr_q    <= '0;
            sram_data_o_q  <= '0;
            sram_data_oe_q <= 1'b0;
            sram_we_n_q    <= 1'b1;
            ack_a_q        <= 1'b0;
            ack_b_q        <= 1'b0;
            rdata_a_q      <= '0;
            rdata_b_q      <= '0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            we_q           <= we_d;
            port_q         <= port_d;
            last_b_q       <= last_b_d;
            sram_addr_q    <= sram_addr_d;
            sram_data_o_q  <= sram_data_o_d;
            sram_data_oe_q <= sram_data_oe_d;
            sram_we_n_q    <= sram_we_n_d;
            ack_a_q        <= ack_a_d;
            ack_b_q        <= ack_b_d;
            rdata_a_q      <= rdata_a_d;
            rdata_b_q      <= rdata_b_d;
            busy_q         <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_vld) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (cnt_q == 4'd0) state_d = RECOVER;
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d          = cnt_q;
        we_d           = we_q;
        port_d         = port_q;
        last_b_d       = last_b_q;
        sram_addr_d    = sram_addr_q;
        sram_data_o_d  = sram_data_o_q;
        sram_data_oe_d = sram_data_oe_q;
        sram_we_n_d    = sram_we_n_q;
        ack_a_d        = 1'b0;
        ack_b_d        = 1'b0;
        rdata_a_d      = rdata_a_q;
        rdata_b_d      = rdata_b_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    port_d         = grant_b;
                    last_b_d       = grant_b;
                    we_d           = grant_b ? bus.we_b : bus.we_a;
                    sram_addr_d    = grant_b ? bus.addr_b : bus.addr_a;
                    sram_data_oe_d = we_d;
                    if (we_d) sram_data_o_d = grant_b ? bus.wdata_b : bus.wdata_a;
                end
            end
            SETUP: begin
                cnt_d       = CNT_INIT;
                sram_we_n_d = !we_q;
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    sram_we_n_d = 1'b1;
                    ack_a_d     = !port_q;
                    ack_b_d     = port_q;
                    if (!we_q) begin
                        if (port_q) rdata_b_d = bus.sram_data_i;
                        else        rdata_a_d = bus.sram_data_i;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RECOVER: sram_data_oe_d = 1'b0;
            default: ;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign bus.sram_addr    = sram_addr_q;
    assign bus.sram_data_o  = sram_data_o_q;
    assign bus.sram_data_oe = sram_data_oe_q;
    assign bus.sram_we_n    = sram_we_n_q;
    assign bus.ack_a        = ack_a_q;
    assign bus.ack_b        = ack_b_q;
    assign bus.rdata_a      = rdata_a_q;
    assign bus.rdata_b      = rdata_b_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_sram_arbiter_2p.sv
// Bench for sram_arbiter_2p: WAIT_CYCLES=3 and WAIT_CYCLES=1 instances, shared SRAM model,
// ack scoreboard fed at request time and drained by a negedge monitor.
module tb_sram_arbiter_2p;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_arbiter_2p_if #(.ADDR_W(21), .DATA_W(8)) if3 ();
    sram_arbiter_2p_if #(.ADDR_W(21), .DATA_W(8)) if1 ();

    sram_arbiter_2p #(.ADDR_W(21), .DATA_W(8), .WAIT_CYCLES(3)) u_dut3 (
        .clk_chipset(clk), .reset(reset), .bus(if3));
    sram_arbiter_2p #(.ADDR_W(21), .DATA_W(8), .WAIT_CYCLES(1)) u_dut1 (
        .clk_chipset(clk), .reset(reset), .bus(if1));

    // SRAM model: 4 KiB window on the low address bits, written only by the WAIT_CYCLES=3 instance.
    logic [7:0] mem [0:4095];
    always @(posedge clk) begin
        if (cyc == 0) mem[12'h012] <= 8'hC3;
        else if (!if3.sram_we_n) mem[if3.sram_addr[11:0]] <= if3.sram_data_o;
    end
    assign if3.sram_data_i = mem[if3.sram_addr[11:0]];
    assign if1.sram_data_i = mem[if1.sram_addr[11:0]];

    typedef struct {
        int         cyc;
        logic       rd;
        logic [7:0] rdata;
    } exp_t;

    exp_t qa3[$];
    exp_t qb3[$];
    exp_t qa1[$];
    exp_t e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (if3.ack_a) begin
            chk("ack_a3_overlap", 32'(if3.ack_b), 0);
            chk("ack_a3_expected", 32'(qa3.size() != 0), 1);
            if (qa3.size() != 0) begin
                e = qa3.pop_front();
                chk("ack_a3_cycle", e.cyc, cyc);
                if (e.rd) chk("rdata_a3", 32'(if3.rdata_a), 32'(e.rdata));
            end
        end
        if (if3.ack_b) begin
            chk("ack_b3_expected", 32'(qb3.size() != 0), 1);
            if (qb3.size() != 0) begin
                e = qb3.pop_front();
                chk("ack_b3_cycle", e.cyc, cyc);
                if (e.rd) chk("rdata_b3", 32'(if3.rdata_b), 32'(e.rdata));
            end
        end
        if (if1.ack_a) begin
            chk("ack_a1_expected", 32'(qa1.size() != 0), 1);
            if (qa1.size() != 0) begin
                e = qa1.pop_front();
                chk("ack_a1_cycle", e.cyc, cyc);
                if (e.rd) chk("rdata_a1", 32'(if1.rdata_a), 32'(e.rdata));
            end
        end
        if (if1.ack_b) chk("ack_b1_spurious", 32'(if1.ack_b), 0);
    end

    task automatic zero_inputs();
        if3.req_a = 1'b0; if3.we_a = 1'b0; if3.addr_a = '0; if3.wdata_a = '0;
        if3.req_b = 1'b0; if3.we_b = 1'b0; if3.addr_b = '0; if3.wdata_b = '0;
        if1.req_a = 1'b0; if1.we_a = 1'b0; if1.addr_a = '0; if1.wdata_a = '0;
        if1.req_b = 1'b0; if1.we_b = 1'b0; if1.addr_b = '0; if1.wdata_b = '0;
    endtask

    int t0;

    initial begin
        // Reset with random port inputs
        reset = 1'b1;
        if3.req_a = 1'($urandom); if3.we_a = 1'($urandom); if3.addr_a = 21'($urandom); if3.wdata_a = 8'($urandom);
        if3.req_b = 1'($urandom); if3.we_b = 1'($urandom); if3.addr_b = 21'($urandom); if3.wdata_b = 8'($urandom);
        if1.req_a = 1'($urandom); if1.we_a = 1'($urandom); if1.addr_a = 21'($urandom); if1.wdata_a = 8'($urandom);
        if1.req_b = 1'($urandom); if1.we_b = 1'($urandom); if1.addr_b = 21'($urandom); if1.wdata_b = 8'($urandom);
        tick();
        @(negedge clk);
        chk("rst_we_n",  32'(if3.sram_we_n), 1);
        chk("rst_oe",    32'(if3.sram_data_oe), 0);
        chk("rst_ack_a", 32'(if3.ack_a), 0);
        chk("rst_ack_b", 32'(if3.ack_b), 0);
        chk("rst_busy",  32'(if3.busy), 0);
        chk("rst_addr",  32'(if3.sram_addr), 0);
        chk("rst1_we_n", 32'(if1.sram_we_n), 1);
        chk("rst1_busy", 32'(if1.busy), 0);
        tick();
        reset = 1'b0;
        zero_inputs();

        // Port A write 0x1ABCD <= 0x5A; req withdrawn right after grant
        tick();
        if3.req_a = 1'b1; if3.we_a = 1'b1; if3.addr_a = 21'h1ABCD; if3.wdata_a = 8'h5A;
        t0 = cyc;
        qa3.push_back('{cyc: t0 + 5, rd: 1'b0, rdata: 8'h00});
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) if3.req_a = 1'b0;
            @(negedge clk);
            if (k <= 5) begin
                chk("wr_addr",   32'(if3.sram_addr), 32'h1ABCD);
                chk("wr_data_o", 32'(if3.sram_data_o), 32'h5A);
            end
            chk("wr_oe",   32'(if3.sram_data_oe), (k <= 5) ? 1 : 0);
            chk("wr_we_n", 32'(if3.sram_we_n), (k >= 2 && k <= 4) ? 0 : 1);
            chk("wr_busy", 32'(if3.busy), (k <= 5) ? 1 : 0);
        end

        // Port B read 0x1ABCD
        tick();
        if3.req_b = 1'b1; if3.we_b = 1'b0; if3.addr_b = 21'h1ABCD;
        t0 = cyc;
        qb3.push_back('{cyc: t0 + 5, rd: 1'b1, rdata: 8'h5A});
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) if3.req_b = 1'b0;
            @(negedge clk);
            if (k <= 5) chk("rd_addr", 32'(if3.sram_addr), 32'h1ABCD);
            chk("rd_we_n",    32'(if3.sram_we_n), 1);
            chk("rd_oe",      32'(if3.sram_data_oe), 0);
            chk("rd_rdata_a", 32'(if3.rdata_a), 0);
        end

        // Reset during the 2nd ACCESS cycle of a port A write; no ack may follow
        tick();
        if3.req_a = 1'b1; if3.we_a = 1'b1; if3.addr_a = 21'h00077; if3.wdata_a = 8'h99;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) if3.req_a = 1'b0;
            if (k == 3) reset = 1'b1;
            if (k == 4) reset = 1'b0;
            @(negedge clk);
            if (k == 3) chk("mid_we_n_before", 32'(if3.sram_we_n), 0);
            if (k == 4) begin
                chk("mid_we_n", 32'(if3.sram_we_n), 1);
                chk("mid_oe",   32'(if3.sram_data_oe), 0);
                chk("mid_busy", 32'(if3.busy), 0);
                chk("mid_addr", 32'(if3.sram_addr), 0);
            end
        end
        repeat (3) tick();
        if3.req_a = 1'b1; if3.we_a = 1'b0; if3.addr_a = 21'h00012;
        t0 = cyc;
        qa3.push_back('{cyc: t0 + 5, rd: 1'b1, rdata: 8'hC3});
        tick();
        if3.req_a = 1'b0;
        repeat (6) tick();

        // Both ports requesting continuously from reset
        reset = 1'b1;
        if3.req_a = 1'b1; if3.we_a = 1'b0; if3.addr_a = 21'h1ABCD;
        if3.req_b = 1'b1; if3.we_b = 1'b0; if3.addr_b = 21'h00012;
        tick();
        tick();
        reset = 1'b0;
        t0 = cyc;
        qa3.push_back('{cyc: t0 + 5,  rd: 1'b1, rdata: 8'h5A});
        qb3.push_back('{cyc: t0 + 11, rd: 1'b1, rdata: 8'hC3});
        qa3.push_back('{cyc: t0 + 17, rd: 1'b1, rdata: 8'h5A});
        qb3.push_back('{cyc: t0 + 23, rd: 1'b1, rdata: 8'hC3});
        repeat (24) tick();
        if3.req_a = 1'b0;
        if3.req_b = 1'b0;
        repeat (3) tick();

        // WAIT_CYCLES=1: read, req held so the next grant lands in cycle 4
        if1.req_a = 1'b1; if1.we_a = 1'b0; if1.addr_a = 21'h1ABCD;
        t0 = cyc;
        qa1.push_back('{cyc: t0 + 3, rd: 1'b1, rdata: 8'h5A});
        qa1.push_back('{cyc: t0 + 7, rd: 1'b1, rdata: 8'h5A});
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 5) if1.req_a = 1'b0;
            @(negedge clk);
            chk("w1_we_n", 32'(if1.sram_we_n), 1);
            if (k == 4) chk("w1_busy_idle", 32'(if1.busy), 0);
            if (k == 5) chk("w1_busy_regrant", 32'(if1.busy), 1);
        end

        repeat (3) tick();
        chk("pending_a3", qa3.size(), 0);
        chk("pending_b3", qb3.size(), 0);
        chk("pending_a1", qa1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sram_arbiter_2p.md
Name: sram_arbiter_2p

Overview:
- Two-port arbiter and sequencer for the single external 8-bit asynchronous SRAM (21-bit address, active-low write enable) on the UnoXT board.
- Shares the SRAM between port A (CPU/chipset bus) and port B (video/DMA fetch) using round-robin arbitration.
- Generates the full read/write cycle timing: address setup, write-enable pulse, data hold, read sampling.
- Sits between the system core and the top-level pin tristate; the top level builds the bidirectional data pin from sram_data_o/sram_data_oe/sram_data_i.

Parameters:
- ADDR_W, 21, SRAM address width.
- DATA_W, 8, SRAM data width.
- WAIT_CYCLES, 3, number of ACCESS cycles (WE low for writes, read settle time); legal range 1..15.

Ports:
- clk_chipset  in  1  system clock (50 MHz); all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_a  in  1  port A request; held high until ack_a.
- we_a  in  1  port A write (1) / read (0).
- addr_a  in  ADDR_W  port A address.
- wdata_a  in  DATA_W  port A write data.
- rdata_a  out  DATA_W  port A read data; valid with ack_a, held until the next port A read ack.
- ack_a  out  1  single-cycle completion pulse for port A.
- req_b, we_b, addr_b, wdata_b, rdata_b, ack_b: same as port A, for port B.
- sram_addr  out  ADDR_W  SRAM address.
- sram_data_o  out  DATA_W  SRAM write data.
- sram_data_oe  out  1  drive enable for the data pins.
- sram_data_i  in  DATA_W  SRAM data pins as read back.
- sram_we_n  out  1  SRAM write enable, active low.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Clock and reset: one clock, clk_chipset; reset is synchronous and active-high.
- Registered outputs: all outputs are registered; there are no combinational paths from inputs to outputs.
- Reset values:
  - state = IDLE; sram_we_n = 1; sram_data_oe = 0.
  - sram_addr = 0; sram_data_o = 0.
  - ack_a = ack_b = 0; rdata_a = rdata_b = 0; busy = 0.
  - last_served = B, so port A wins the first tie.
- States: IDLE -> SETUP -> ACCESS (WAIT_CYCLES cycles) -> RECOVER -> IDLE.
- IDLE:
  - If only one port requests, grant that port.
  - If both request, grant the port other than last_served.
  - On grant: latch the port's addr, we and wdata; load sram_addr; for a write, load sram_data_o and set sram_data_oe = 1; update last_served; go to SETUP.
  - Requests are sampled only in IDLE.
- SETUP: one cycle; address (and write data) are stable, sram_we_n = 1.
- ACCESS:
  - Counter runs WAIT_CYCLES-1 down to 0.
  - Write: sram_we_n = 0 for exactly WAIT_CYCLES cycles.
  - Read: on the edge leaving the last ACCESS cycle, sram_data_i is captured into rdata of the granted port.
- RECOVER: one cycle.
  - sram_we_n = 1; for a write, data is still driven (one cycle of hold).
  - Ack of the granted port = 1 for this cycle only.
  - On exit: sram_data_oe = 0, return to IDLE.
- Latency and throughput:
  - With req sampled in IDLE at cycle 0, ack is high in cycle WAIT_CYCLES+2.
  - The earliest next grant is cycle WAIT_CYCLES+3, giving a period of WAIT_CYCLES+3 cycles per access.
- Back-to-back:
  - A requester may keep req high after ack to issue its next transaction; it must present new addr/we/wdata no later than the cycle after ack.
  - With both ports continuously requesting, grants alternate A, B, A, B.
- Request withdrawal: a req dropped after grant does not abort the transaction; it completes and acks. A req dropped before grant is ignored.
- Read data ownership: the rdata of the non-granted port never changes.
- Address and data stability: sram_addr is unchanged from SETUP through RECOVER.
- Reset mid-transaction: on the next edge all outputs return to reset values (sram_we_n = 1, oe = 0); the transaction is dropped and no ack is issued.

Test Plan:
- Reset: assert reset 2 cycles with random port inputs -> sram_we_n=1, sram_data_oe=0, ack_a=ack_b=0, busy=0, sram_addr=0.
- Port A write, WAIT_CYCLES=3, addr_a=0x1ABCD, wdata_a=0x5A, req at cycle 0:
  - sram_addr=0x1ABCD for cycles 1-5.
  - sram_data_oe=1 and sram_data_o=0x5A for cycles 1-5.
  - sram_we_n=0 for cycles 2-4 only.
  - ack_a=1 in cycle 5 only.
- Port B read of 0x1ABCD, with the SRAM model returning 0x5A -> ack_b in cycle 5, rdata_b=0x5A, sram_we_n stays 1, oe stays 0, rdata_a unchanged.
- Both ports requesting continuously from reset -> ack order A, B, A, B; successive acks exactly 6 cycles apart; no cycle has both acks high.
- Reset asserted in the 2nd ACCESS cycle of a port A write -> next cycle sram_we_n=1, sram_data_oe=0, busy=0; ack_a never pulses; the following request is granted normally.
- WAIT_CYCLES=1 instance, port A read -> sram_we_n stays 1, ack_a in cycle 3, next grant possible in cycle 4.
